// File: rtl/wb_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the Wishbone bus arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } wb_state_e;

    localparam int ADR_W = 30;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    // Requests above NUM_MASTERS are zero, so scanning modulo 4 gives the same
    // order of real masters as scanning modulo NUM_MASTERS.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts unanswered strobe cycles and tallies aborts (saturating).
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk100,
    input  logic        reset_n,
    input  logic        active,
    input  logic        stb,
    input  logic        term,
    output logic        expire,
    output logic [15:0] timeout_count
);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [15:0] timeout_count_q;
    logic [15:0] timeout_count_d;

    // An answer in the last allowed cycle wins over the abort.
    assign expire = active && stb && !term && (count_q == 16'(TIMEOUT - 1));

    always_comb begin
        count_d         = count_q + 16'd1;
        timeout_count_d = timeout_count_q;
        if (!active || !stb || term || expire) begin
            count_d = '0;
        end
        if (expire && (timeout_count_q != 16'hFFFF)) begin
            timeout_count_d = timeout_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            count_q         <= '0;
            timeout_count_q <= '0;
        end else begin
            count_q         <= count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign timeout_count = timeout_count_q;

endmodule

// File: rtl/wishbone_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between several masters,
// holding the grant for a whole cyc and aborting accesses the slave leaves hanging.
module wishbone_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                         clk100,
    input  logic                         reset_n,
    input  logic [ADR_W*NUM_MASTERS-1:0] m_adr,
    input  logic [DAT_W*NUM_MASTERS-1:0] m_datwr,
    input  logic [SEL_W*NUM_MASTERS-1:0] m_sel,
    input  logic [3*NUM_MASTERS-1:0]     m_cti,
    input  logic [2*NUM_MASTERS-1:0]     m_bte,
    input  logic [NUM_MASTERS-1:0]       m_cyc,
    input  logic [NUM_MASTERS-1:0]       m_stb,
    input  logic [NUM_MASTERS-1:0]       m_we,
    output logic [DAT_W-1:0]             m_datrd,
    output logic [NUM_MASTERS-1:0]       m_ack,
    output logic [NUM_MASTERS-1:0]       m_err,
    output logic [ADR_W-1:0]             wishbone_adr,
    output logic [DAT_W-1:0]             wishbone_datwr,
    output logic [SEL_W-1:0]             wishbone_sel,
    output logic [2:0]                   wishbone_cti,
    output logic [1:0]                   wishbone_bte,
    output logic                         wishbone_cyc,
    output logic                         wishbone_stb,
    output logic                         wishbone_we,
    input  logic [DAT_W-1:0]             wishbone_datrd,
    input  logic                         wishbone_ack,
    input  logic                         wishbone_err,
    output logic [1:0]                   grant,
    output logic                         busy,
    output logic [15:0]                  timeout_count
);

    wb_state_e  state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] last_grant_q, last_grant_d;

    logic [ADR_W-1:0] sel_adr;
    logic [DAT_W-1:0] sel_datwr;
    logic [SEL_W-1:0] sel_sel;
    logic [2:0]       sel_cti;
    logic [1:0]       sel_bte;
    logic             sel_cyc;
    logic             sel_stb;
    logic             sel_we;
    logic             owned;
    logic             expire;

    assign owned = (state_q == BUSY);

    always_comb begin
        sel_adr   = '0;
        sel_datwr = '0;
        sel_sel   = '0;
        sel_cti   = '0;
        sel_bte   = '0;
        sel_cyc   = 1'b0;
        sel_stb   = 1'b0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q == 2'(i)) begin
                sel_adr   = m_adr[i*ADR_W +: ADR_W];
                sel_datwr = m_datwr[i*DAT_W +: DAT_W];
                sel_sel   = m_sel[i*SEL_W +: SEL_W];
                sel_cti   = m_cti[i*3 +: 3];
                sel_bte   = m_bte[i*2 +: 2];
                sel_cyc   = m_cyc[i];
                sel_stb   = m_stb[i];
                sel_we    = m_we[i];
            end
        end
    end

    // Outside BUSY the slave sees an all-zero bus, so ABORT and reset need no extra gating.
    assign wishbone_cyc   = owned & sel_cyc;
    assign wishbone_stb   = owned & sel_cyc & sel_stb;
    assign wishbone_we    = owned & sel_we;
    assign wishbone_adr   = owned ? sel_adr   : '0;
    assign wishbone_datwr = owned ? sel_datwr : '0;
    assign wishbone_sel   = owned ? sel_sel   : '0;
    assign wishbone_cti   = owned ? sel_cti   : '0;
    assign wishbone_bte   = owned ? sel_bte   : '0;
    assign m_datrd        = owned ? wishbone_datrd : '0;

    always_comb begin
        m_ack = '0;
        m_err = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owned && (grant_q == 2'(i))) begin
                m_ack[i] = wishbone_ack;
                m_err[i] = wishbone_err | expire;
            end
        end
    end

    wb_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk100       (clk100),
        .reset_n      (reset_n),
        .active       (owned),
        .stb          (wishbone_stb),
        .term         (wishbone_ack | wishbone_err),
        .expire       (expire),
        .timeout_count(timeout_count)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc) begin
                    grant_d = rr_pick(4'(m_cyc), last_grant_q);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!sel_cyc) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else if (expire) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (!sel_cyc) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'(NUM_MASTERS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Directed self-checking bench for wishbone_bus_arbiter (2 masters, TIMEOUT=8).
module tb_wishbone_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;

    logic            clk100 = 1'b0;
    logic            reset_n;
    logic [30*N-1:0] m_adr;
    logic [32*N-1:0] m_datwr;
    logic [4*N-1:0]  m_sel;
    logic [3*N-1:0]  m_cti;
    logic [2*N-1:0]  m_bte;
    logic [N-1:0]    m_cyc;
    logic [N-1:0]    m_stb;
    logic [N-1:0]    m_we;
    logic [31:0]     m_datrd;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_err;
    logic [29:0]     wishbone_adr;
    logic [31:0]     wishbone_datwr;
    logic [3:0]      wishbone_sel;
    logic [2:0]      wishbone_cti;
    logic [1:0]      wishbone_bte;
    logic            wishbone_cyc;
    logic            wishbone_stb;
    logic            wishbone_we;
    logic [31:0]     wishbone_datrd;
    logic            wishbone_ack;
    logic            wishbone_err;
    logic [1:0]      grant;
    logic            busy;
    logic [15:0]     timeout_count;

    int checkCount = 0;
    int passCount  = 0;

    wishbone_bus_arbiter #(
        .NUM_MASTERS(N),
        .TIMEOUT    (TO)
    ) dut (
        .clk100        (clk100),
        .reset_n       (reset_n),
        .m_adr         (m_adr),
        .m_datwr       (m_datwr),
        .m_sel         (m_sel),
        .m_cti         (m_cti),
        .m_bte         (m_bte),
        .m_cyc         (m_cyc),
        .m_stb         (m_stb),
        .m_we          (m_we),
        .m_datrd       (m_datrd),
        .m_ack         (m_ack),
        .m_err         (m_err),
        .wishbone_adr  (wishbone_adr),
        .wishbone_datwr(wishbone_datwr),
        .wishbone_sel  (wishbone_sel),
        .wishbone_cti  (wishbone_cti),
        .wishbone_bte  (wishbone_bte),
        .wishbone_cyc  (wishbone_cyc),
        .wishbone_stb  (wishbone_stb),
        .wishbone_we   (wishbone_we),
        .wishbone_datrd(wishbone_datrd),
        .wishbone_ack  (wishbone_ack),
        .wishbone_err  (wishbone_err),
        .grant         (grant),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    always #5 clk100 = ~clk100;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic cyc, input logic stb, input logic we,
                                 input logic [29:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic [2:0] cti);
        m_cyc[idx]            = cyc;
        m_stb[idx]            = stb;
        m_we[idx]             = we;
        m_adr[idx*30 +: 30]   = adr;
        m_datwr[idx*32 +: 32] = dat;
        m_sel[idx*4 +: 4]     = sel;
        m_cti[idx*3 +: 3]     = cti;
    endtask

    // Lands 1 time unit after the rising edge so registered state has settled.
    task automatic nextCycle();
        @(posedge clk100);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int expGrant;

        reset_n        = 1'b0;
        m_adr          = '0;
        m_datwr        = '0;
        m_sel          = '0;
        m_cti          = '0;
        m_bte          = '0;
        m_cyc          = '0;
        m_stb          = '0;
        m_we           = '0;
        wishbone_datrd = '0;
        wishbone_ack   = 1'b0;
        wishbone_err   = 1'b0;

        #12;
        checkOutput("rst_cyc",   32'(wishbone_cyc), 0);
        checkOutput("rst_busy",  32'(busy), 0);
        checkOutput("rst_grant", 32'(grant), 0);
        checkOutput("rst_tocnt", 32'(timeout_count), 0);
        checkOutput("rst_ack",   32'(m_ack), 0);
        reset_n = 1'b1;
        nextCycle();

        $display("[TB] single read");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h10, 32'h0, 4'hF, 3'b000);
        #1;
        checkOutput("rd_idle_cyc", 32'(wishbone_cyc), 0);
        nextCycle();
        checkOutput("rd_cyc",   32'(wishbone_cyc), 1);
        checkOutput("rd_adr",   32'(wishbone_adr), 32'h10);
        checkOutput("rd_grant", 32'(grant), 0);
        checkOutput("rd_wait1", 32'(m_ack), 0);
        nextCycle();
        checkOutput("rd_wait2", 32'(m_ack), 0);
        nextCycle();
        wishbone_ack   = 1'b1;
        wishbone_datrd = 32'hDEADBEEF;
        #1;
        checkOutput("rd_ack",  32'(m_ack), 32'h1);
        checkOutput("rd_data", m_datrd, 32'hDEADBEEF);
        nextCycle();
        wishbone_ack   = 1'b0;
        wishbone_datrd = '0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h10, 32'h0, 4'hF, 3'b000);
        #1;
        checkOutput("rd_ack_once", 32'(m_ack), 0);
        checkOutput("rd_cyc_fall", 32'(wishbone_cyc), 0);
        nextCycle();
        checkOutput("rd_done_idle", 32'(busy), 0);

        $display("[TB] round robin");
        m_cyc = 2'b11;
        m_stb = 2'b11;
        expGrant = 1;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            checkOutput("rr_grant", 32'(grant), 32'(expGrant));
            checkOutput("rr_busy",  32'(busy), 1);
            wishbone_ack = 1'b1;
            #1;
            checkOutput("rr_ack", 32'(m_ack), (expGrant == 1) ? 32'h2 : 32'h1);
            nextCycle();
            wishbone_ack    = 1'b0;
            m_cyc[expGrant] = 1'b0;
            m_stb[expGrant] = 1'b0;
            #1;
            checkOutput("rr_cyc_drop", 32'(wishbone_cyc), 0);
            nextCycle();
            checkOutput("rr_idle", 32'(busy), 0);
            if (k < 3) begin
                m_cyc = 2'b11;
                m_stb = 2'b11;
            end else begin
                m_cyc = 2'b00;
                m_stb = 2'b00;
            end
            expGrant = 1 - expGrant;
        end

        $display("[TB] isolation");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h10, 32'h1234, 4'h3, 3'b000);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 30'h20, 32'h55AA, 4'hF, 3'b000);
        nextCycle();
        checkOutput("iso_grant", 32'(grant), 1);
        checkOutput("iso_adr",   32'(wishbone_adr), 32'h20);
        checkOutput("iso_dat",   wishbone_datwr, 32'h55AA);
        checkOutput("iso_sel",   32'(wishbone_sel), 32'hF);
        checkOutput("iso_we",    32'(wishbone_we), 1);
        checkOutput("iso_err",   32'(m_err), 0);
        nextCycle();
        checkOutput("iso_m0_wait", 32'(m_ack), 0);
        wishbone_ack = 1'b1;
        #1;
        checkOutput("iso_m1_ack", 32'(m_ack), 32'h2);
        nextCycle();
        wishbone_ack = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 30'h20, 32'h55AA, 4'hF, 3'b000);
        nextCycle();
        checkOutput("iso_turn_idle", 32'(busy), 0);
        checkOutput("iso_turn_ack",  32'(m_ack), 0);
        nextCycle();
        checkOutput("iso_m0_grant", 32'(grant), 0);
        checkOutput("iso_m0_adr",   32'(wishbone_adr), 32'h10);
        checkOutput("iso_m0_sel",   32'(wishbone_sel), 32'h3);
        wishbone_err = 1'b1;
        #1;
        checkOutput("iso_m0_err",   32'(m_err), 32'h1);
        checkOutput("iso_m0_noack", 32'(m_ack), 0);
        nextCycle();
        wishbone_err = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h10, 32'h0, 4'h3, 3'b000);
        nextCycle();

        $display("[TB] timeout");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h40, 32'h0, 4'hF, 3'b000);
        nextCycle();
        for (int c = 1; c < TO; c++) begin
            checkOutput("to_wait_err", 32'(m_err), 0);
            nextCycle();
        end
        checkOutput("to_err",       32'(m_err), 32'h1);
        checkOutput("to_cyc_still", 32'(wishbone_cyc), 1);
        checkOutput("to_cnt_pre",   32'(timeout_count), 0);
        nextCycle();
        checkOutput("to_cyc_off", 32'(wishbone_cyc), 0);
        checkOutput("to_stb_off", 32'(wishbone_stb), 0);
        checkOutput("to_busy",    32'(busy), 1);
        checkOutput("to_cnt",     32'(timeout_count), 1);
        wishbone_ack = 1'b1;
        #1;
        checkOutput("to_late_ack", 32'(m_ack), 0);
        nextCycle();
        wishbone_ack = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h40, 32'h0, 4'hF, 3'b000);
        nextCycle();
        checkOutput("to_idle", 32'(busy), 0);

        $display("[TB] ack on boundary");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h44, 32'h0, 4'hF, 3'b000);
        nextCycle();
        for (int c = 1; c < TO; c++) begin
            nextCycle();
        end
        wishbone_ack = 1'b1;
        #1;
        checkOutput("bnd_ack", 32'(m_ack), 32'h1);
        checkOutput("bnd_err", 32'(m_err), 0);
        nextCycle();
        wishbone_ack = 1'b0;
        #1;
        checkOutput("bnd_cnt",  32'(timeout_count), 1);
        checkOutput("bnd_busy", 32'(wishbone_cyc), 1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 30'h44, 32'h0, 4'hF, 3'b000);
        nextCycle();

        $display("[TB] reset mid-burst");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 30'h80, 32'h0, 4'hF, 3'b010);
        nextCycle();
        checkOutput("rb_cti", 32'(wishbone_cti), 32'h2);
        wishbone_ack = 1'b1;
        reset_n      = 1'b0;
        #1;
        checkOutput("rb_cyc",   32'(wishbone_cyc), 0);
        checkOutput("rb_stb",   32'(wishbone_stb), 0);
        checkOutput("rb_cti0",  32'(wishbone_cti), 0);
        checkOutput("rb_adr",   32'(wishbone_adr), 0);
        checkOutput("rb_ack",   32'(m_ack), 0);
        checkOutput("rb_busy",  32'(busy), 0);
        checkOutput("rb_tocnt", 32'(timeout_count), 0);
        wishbone_ack = 1'b0;
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 30'h90, 32'h0, 4'hF, 3'b000);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        checkOutput("rb_first_grant", 32'(grant), 0);
        checkOutput("rb_first_busy",  32'(busy), 1);
        m_cyc = '0;
        m_stb = '0;
        nextCycle();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/wishbone_bus_arbiter.md
# wishbone_bus_arbiter

Round-robin arbiter that shares the USB device core's single Wishbone slave port between several bus masters, e.g. the cocotb host-side sequencer and a background CSR/endpoint poller. It holds the grant for a whole `cyc` cycle and never interleaves transactions. A watchdog ends any access the slave leaves hanging: the arbiter returns `err` to the requester and releases the bus. It sits between the testbench masters and the DUT's `wishbone_*` pins, in the `clk100` domain.

## Interface
- `NUM_MASTERS`, default 2: number of requesters, legal range 2..4.
- `TIMEOUT`, default 1024: number of stalled strobe cycles before an abort; legal range 2..65535.
- `clk100` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `m_adr` in 30×N: per-master word address, packed, master i at [30i+29:30i].
- `m_datwr` in 32×N: per-master write data.
- `m_sel` in 4×N: per-master byte selects.
- `m_cti` in 3×N, `m_bte` in 2×N: per-master burst qualifiers, passed through.
- `m_cyc`, `m_stb`, `m_we` in N: per-master cycle, strobe and write enable.
- `m_datrd` out 32: slave read data, broadcast to all masters.
- `m_ack`, `m_err` out N: per-master terminations; only the granted bit can be 1.
- `wishbone_adr` out 30, `wishbone_datwr` out 32, `wishbone_sel` out 4, `wishbone_cti` out 3, `wishbone_bte` out 2: to the DUT.
- `wishbone_cyc`, `wishbone_stb`, `wishbone_we` out 1: to the DUT.
- `wishbone_datrd` in 32, `wishbone_ack` in 1, `wishbone_err` in 1: from the DUT.
- `grant` out 2: index of the current owner; valid while `busy`.
- `busy` out 1: the bus is owned (state BUSY or ABORT).
- `timeout_count` out 16: number of aborts since reset; saturates at 0xFFFF.

## Operation
- **Reset values.** State IDLE, `grant`=0, `last_grant`=N-1 (so master 0 wins first), watchdog counter 0, `timeout_count`=0. All `wishbone_*` outputs and all `m_ack`/`m_err` are 0.
- **IDLE.**
  - Slave outputs are held at 0.
  - If any `m_cyc` is high, select the first requester scanning `last_grant+1`, `last_grant+2`, … modulo N.
  - Register the result into `grant` and go to BUSY.
- **BUSY.**
  - The granted master's address, data, controls, `cyc` and `stb` drive the slave combinationally.
  - `wishbone_ack` and `wishbone_err` route to `m_ack[grant]` and `m_err[grant]`; all other bits are 0.
  - Watchdog: increments on each cycle with `wishbone_stb=1` and no ack/err, and clears on ack, on err, or when `stb` is low.
  - If the counter equals TIMEOUT-1 and there is no ack/err in that cycle:
    - pulse `m_err[grant]` for that cycle;
    - force `wishbone_cyc` and `wishbone_stb` to 0 from the next cycle;
    - increment `timeout_count`;
    - go to ABORT.
  - When `m_cyc[grant]` falls: `wishbone_cyc` falls in the same cycle, then `last_grant`←`grant` and the state returns to IDLE.
- **ABORT.**
  - Slave `cyc`/`stb` are held at 0; a late `wishbone_ack` or `wishbone_err` is discarded.
  - Wait for `m_cyc[grant]`=0, then set `last_grant`←`grant` and go to IDLE.
- **Simultaneous events.** An ack arriving in the timeout cycle wins: no err, no count. Other masters that request while the bus is owned simply wait, with no ack or err.
- **Reset mid-transfer.** Every output clears immediately (asynchronously), with no termination returned to the master.

## Timing
- Arbitration latency is 1 cycle: `m_cyc` sampled high at edge k gives `wishbone_cyc`=1 in the cycle after edge k.
- Ack/err/data return is combinational: 0 added cycles in BUSY.
- Bus turnaround is 1 idle cycle minimum between owners, because IDLE always occupies one cycle.
- Timeout error: a slave that never answers produces `m_err` in the TIMEOUT-th cycle of asserted `stb`.

## Structure
- Package `wb_arb_pkg` holds:
  - the state enum {IDLE, BUSY, ABORT};
  - the width constants ADR_W=30, DAT_W=32, SEL_W=4;
  - the function `rr_pick(req, last)` that returns the next index.
- Sub-module `wb_arb_watchdog` contains the counter, compare and saturating `timeout_count`. Muxing and the FSM stay in the top level.

## Test plan
- **Single read.** M0 reads 0x0000_0010; the slave acks after 3 cycles with 0xDEADBEEF → `m_datrd`=0xDEADBEEF, `m_ack[0]` for 1 cycle, `wishbone_cyc` high 1 cycle after the request.
- **Round-robin.** M0 and M1 both request continuously → grants alternate 0,1,0,1, with exactly one IDLE cycle between owners.
- **Timeout.** TIMEOUT=8, slave silent → `m_err[0]` in the 8th strobe cycle, `wishbone_cyc`=0 the next cycle, `timeout_count`=1. A late ack in ABORT is not seen by M0.
- **Ack on boundary.** The ack arrives in cycle TIMEOUT exactly → `m_ack` only, `timeout_count` unchanged.
- **Isolation.** M1 writes 0x55AA to 0x20 while M0 is waiting → M0 sees no ack/err until it is granted; the DUT sees the M1 address/data unmodified, `sel`=0xF.
- **Reset.** `reset_n` falls mid-burst (`cti`=010) → all outputs are 0 immediately; after release, M0 is granted first.
